// File: rtl/bus_rr_arbiter_pkg.sv
// Shared definitions for the bus_rr_arbiter slice.
// Contents:
//   arb_state_e       FSM state encoding (ARB_IDLE, ARB_BUSY)
//   BYTE_EN_W         width of a byte-enable lane group
//   TIMEOUT_FILL_BIT  bit replicated across the read data of an abandoned transaction
//   idx_width()       index width for a given master count (at least 1 bit)
package bus_rr_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int   BYTE_EN_W        = 4;
    localparam logic TIMEOUT_FILL_BIT = 1'b1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Bundle of all master-side and slave-side bus signals around the arbiter.
// Modports:
//   slave  - the arbiter's view: takes master requests and the slave ack/data,
//            drives the slave request and the per-master ack/read data.
//   master - the surrounding system's view (masters plus shared slave).
// Signals:
//   i_m_bus_en/i_m_wr_en [N]    per-master request and write flag
//   i_m_addr/i_m_wr_data [N*X]  flattened, master k at [k*XLEN +: XLEN]
//   i_m_byte_en [N*4]           flattened byte enables
//   o_m_ack [N], o_m_rd_data    one-hot ack and broadcast read data
//   o_bus_en/o_wr_en/o_addr/o_wr_data/o_byte_en  registered slave request
//   i_ack, i_rd_data            slave response
//   o_timeout                   abandoned-transaction pulse
interface bus_rr_arbiter_if
    import bus_rr_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int XLEN      = 32
);
    logic [N_MASTERS-1:0]           i_m_bus_en;
    logic [N_MASTERS-1:0]           i_m_wr_en;
    logic [N_MASTERS*XLEN-1:0]      i_m_addr;
    logic [N_MASTERS*XLEN-1:0]      i_m_wr_data;
    logic [N_MASTERS*BYTE_EN_W-1:0] i_m_byte_en;
    logic [N_MASTERS-1:0]           o_m_ack;
    logic [XLEN-1:0]                o_m_rd_data;
    logic                           o_bus_en;
    logic                           o_wr_en;
    logic [XLEN-1:0]                o_addr;
    logic [XLEN-1:0]                o_wr_data;
    logic [BYTE_EN_W-1:0]           o_byte_en;
    logic                           i_ack;
    logic [XLEN-1:0]                i_rd_data;
    logic                           o_timeout;

    modport slave (
        input  i_m_bus_en, i_m_wr_en, i_m_addr, i_m_wr_data, i_m_byte_en,
        input  i_ack, i_rd_data,
        output o_m_ack, o_m_rd_data,
        output o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en, o_timeout
    );

    modport master (
        output i_m_bus_en, i_m_wr_en, i_m_addr, i_m_wr_data, i_m_byte_en,
        output i_ack, i_rd_data,
        input  o_m_ack, o_m_rd_data,
        input  o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en, o_timeout
    );
endinterface

// File: rtl/bus_rr_arbiter_rr_priority_pick.sv
// Round-robin pick: scans requests starting at i_ptr and wrapping modulo
// N_MASTERS, returning the first requester found.
// Ports:
//   i_req   [N_MASTERS]  request vector
//   i_ptr   [IDX_W]      index with highest priority (must be < N_MASTERS)
//   o_found              at least one request is set
//   o_idx   [IDX_W]      selected index (0 when none found)
module rr_priority_pick #(
    parameter int N_MASTERS = 2,
    parameter int IDX_W     = 1
) (
    input  logic [N_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_ptr,
    output logic                 o_found,
    output logic [IDX_W-1:0]     o_idx
);
    logic [IDX_W:0] cand;
    logic           hit;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        cand    = '0;
        hit     = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            // Wrap explicitly so non-power-of-two master counts stay in range.
            cand = {1'b0, i_ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N_MASTERS)) begin
                cand = cand - (IDX_W+1)'(N_MASTERS);
            end
            hit = 1'b0;
            for (int k = 0; k < N_MASTERS; k++) begin
                if (cand == (IDX_W+1)'(k)) begin
                    hit = i_req[k];
                end
            end
            if (!o_found && hit) begin
                o_found = 1'b1;
                o_idx   = cand[IDX_W-1:0];
            end
        end
    end
endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter between N_MASTERS bus masters and one shared slave.
// In IDLE the next requester (round-robin from rr_ptr) is latched onto the
// registered slave outputs; in BUSY those outputs are held until the slave
// acks, at which point the ack is routed to the granted master in the same
// cycle and priority moves to the following master.
// Optional feature macro: BUS_ARB_TIMEOUT_EN - abandon a transaction after
// TIMEOUT_CYCLES cycles in BUSY without an ack, acking the master with an
// all-ones read value and pulsing o_timeout. Without it o_timeout is 0.
// Ports:
//   i_clk, i_rst  clock and synchronous active-high reset
//   bus           bus_rr_arbiter_if.slave - all master and slave bus signals
module bus_rr_arbiter
    import bus_rr_arbiter_pkg::*;
#(
    parameter int N_MASTERS      = 2,
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               i_clk,
    input  logic               i_rst,
    bus_rr_arbiter_if.slave    bus
);
    localparam int IDX_W = idx_width(N_MASTERS);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 bus_en_q, bus_en_d;
    logic                 wr_en_q, wr_en_d;
    logic [XLEN-1:0]      addr_q, addr_d;
    logic [XLEN-1:0]      wr_data_q, wr_data_d;
    logic [BYTE_EN_W-1:0] byte_en_q, byte_en_d;

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic                 timeout_hit;
    logic                 ack_fire;
    logic [N_MASTERS-1:0] m_ack;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(N_MASTERS-1)) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

    rr_priority_pick #(
        .N_MASTERS (N_MASTERS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .i_req   (bus.i_m_bus_en),
        .i_ptr   (rr_ptr_q),
        .o_found (pick_found),
        .o_idx   (pick_idx)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A real ack in the limit cycle wins over the timeout.
    assign timeout_hit = (state_q == ARB_BUSY) && !bus.i_ack && !i_rst &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    // Reset discards any slave ack arriving in the same cycle.
    assign ack_fire = (state_q == ARB_BUSY) && !i_rst && (bus.i_ack || timeout_hit);

    always_comb begin
        m_ack = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            m_ack[k] = ack_fire && (gnt_q == IDX_W'(k));
        end
    end

    assign bus.o_m_ack     = m_ack;
    assign bus.o_m_rd_data = timeout_hit ? {XLEN{TIMEOUT_FILL_BIT}} : bus.i_rd_data;
    assign bus.o_timeout   = timeout_hit;
    assign bus.o_bus_en    = bus_en_q;
    assign bus.o_wr_en     = wr_en_q;
    assign bus.o_addr      = addr_q;
    assign bus.o_wr_data   = wr_data_q;
    assign bus.o_byte_en   = byte_en_q;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        bus_en_d  = bus_en_q;
        wr_en_d   = wr_en_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        byte_en_d = byte_en_q;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    gnt_d    = pick_idx;
                    bus_en_d = 1'b1;
                    state_d  = ARB_BUSY;
                    for (int k = 0; k < N_MASTERS; k++) begin
                        if (pick_idx == IDX_W'(k)) begin
                            wr_en_d   = bus.i_m_wr_en[k];
                            addr_d    = bus.i_m_addr[k*XLEN +: XLEN];
                            wr_data_d = bus.i_m_wr_data[k*XLEN +: XLEN];
                            byte_en_d = bus.i_m_byte_en[k*BYTE_EN_W +: BYTE_EN_W];
                        end
                    end
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            ARB_BUSY: begin
                if (ack_fire) begin
                    bus_en_d = 1'b0;
                    rr_ptr_d = next_idx(gnt_q);
                    state_d  = ARB_IDLE;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            rr_ptr_q  <= '0;
            bus_en_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            byte_en_q <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_ptr_q  <= rr_ptr_d;
            bus_en_q  <= bus_en_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            byte_en_q <= byte_en_d;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter (N_MASTERS=2, XLEN=32, TIMEOUT_CYCLES=4).
module tb_bus_rr_arbiter;
    localparam int N  = 2;
    localparam int XL = 32;
    localparam int TO = 4;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    bus_rr_arbiter_if #(.N_MASTERS(N), .XLEN(XL)) bif ();

    bus_rr_arbiter #(
        .N_MASTERS      (N),
        .XLEN           (XL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bif)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int k, input logic en, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be);
        bif.i_m_bus_en[k]             = en;
        bif.i_m_wr_en[k]              = wr;
        bif.i_m_addr[k*XL +: XL]      = addr;
        bif.i_m_wr_data[k*XL +: XL]   = data;
        bif.i_m_byte_en[k*4 +: 4]     = be;
    endtask

    task automatic slave(input logic ack, input logic [31:0] data);
        bif.i_ack     = ack;
        bif.i_rd_data = data;
        #1;
    endtask

    logic [1:0]  exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] exp_adr [4] = '{32'hA0, 32'hB0, 32'hA0, 32'hB0};

    initial begin
        bif.i_m_bus_en  = '0;
        bif.i_m_wr_en   = '0;
        bif.i_m_addr    = '0;
        bif.i_m_wr_data = '0;
        bif.i_m_byte_en = '0;
        bif.i_ack       = 1'b0;
        bif.i_rd_data   = '0;

        // Reset state
        tick();
        tick();
        chk("rst_bus_en", bif.o_bus_en, 1'b0);
        chk("rst_addr", bif.o_addr, 32'h0);
        chk("rst_m_ack", bif.o_m_ack, 2'b00);
        chk("rst_timeout", bif.o_timeout, 1'b0);
        i_rst = 1'b0;

        // Single request: master 1 reads 0x1000
        set_m(1, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
        tick();
        chk("single_bus_en", bif.o_bus_en, 1'b1);
        chk("single_addr", bif.o_addr, 32'h0000_1000);
        chk("single_wr_en", bif.o_wr_en, 1'b0);
        tick();
        chk("single_wait_ack", bif.o_m_ack, 2'b00);
        tick();
        slave(1'b1, 32'hCAFE_F00D);
        chk("single_m_ack", bif.o_m_ack, 2'b10);
        chk("single_rd_data", bif.o_m_rd_data, 32'hCAFE_F00D);
        tick();
        slave(1'b0, 32'h0);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("single_bus_en_clr", bif.o_bus_en, 1'b0);
        chk("single_m_ack_clr", bif.o_m_ack, 2'b00);

        // Spurious ack in IDLE
        slave(1'b1, 32'h1111_2222);
        chk("spur_m_ack", bif.o_m_ack, 2'b00);
        tick();
        slave(1'b0, 32'h0);
        chk("spur_stay_idle", bif.o_bus_en, 1'b0);

        // Contention fairness: both request continuously
        set_m(0, 1'b1, 1'b0, 32'hA0, 32'h0, 4'hF);
        set_m(1, 1'b1, 1'b0, 32'hB0, 32'h0, 4'hF);
        for (int g = 0; g < 4; g++) begin
            tick();
            chk($sformatf("fair_bus_en_%0d", g), bif.o_bus_en, 1'b1);
            chk($sformatf("fair_addr_%0d", g), bif.o_addr, exp_adr[g]);
            slave(1'b1, 32'h100 + 32'(g));
            chk($sformatf("fair_m_ack_%0d", g), bif.o_m_ack, exp_gnt[g]);
            tick();
            slave(1'b0, 32'h0);
            chk($sformatf("fair_idle_%0d", g), bif.o_bus_en, 1'b0);
        end
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // Write latching: master 0 changes inputs while BUSY
        set_m(0, 1'b1, 1'b1, 32'h2000, 32'h1234_5678, 4'b0011);
        tick();
        chk("wr_wr_en", bif.o_wr_en, 1'b1);
        chk("wr_addr", bif.o_addr, 32'h2000);
        set_m(0, 1'b1, 1'b0, 32'hDEAD_0000, 32'h0, 4'b1111);
        tick();
        tick();
        chk("wr_hold_wr_en", bif.o_wr_en, 1'b1);
        chk("wr_hold_addr", bif.o_addr, 32'h2000);
        chk("wr_hold_data", bif.o_wr_data, 32'h1234_5678);
        chk("wr_hold_be", bif.o_byte_en, 4'b0011);
        slave(1'b1, 32'h0);
        chk("wr_m_ack", bif.o_m_ack, 2'b01);
        tick();
        slave(1'b0, 32'h0);
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // Reset mid-transaction coinciding with a slave ack (rr_ptr is 1 here)
        set_m(0, 1'b1, 1'b1, 32'h3000, 32'hAAAA_5555, 4'b1100);
        tick();
        chk("rstmid_busy", bif.o_bus_en, 1'b1);
        i_rst = 1'b1;
        slave(1'b1, 32'h0);
        chk("rstmid_ack_discard", bif.o_m_ack, 2'b00);
        tick();
        i_rst = 1'b0;
        slave(1'b0, 32'h0);
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("rstmid_bus_en", bif.o_bus_en, 1'b0);
        chk("rstmid_wr_en", bif.o_wr_en, 1'b0);
        chk("rstmid_addr", bif.o_addr, 32'h0);
        chk("rstmid_wr_data", bif.o_wr_data, 32'h0);
        chk("rstmid_be", bif.o_byte_en, 4'h0);
        chk("rstmid_m_ack", bif.o_m_ack, 2'b00);
        // rr_ptr back to 0: with both requesting, master 0 wins
        set_m(0, 1'b1, 1'b0, 32'hC0, 32'h0, 4'hF);
        set_m(1, 1'b1, 1'b0, 32'hD0, 32'h0, 4'hF);
        tick();
        chk("rstmid_ptr_addr", bif.o_addr, 32'hC0);
        slave(1'b1, 32'h0);
        chk("rstmid_ptr_ack", bif.o_m_ack, 2'b01);
        tick();
        slave(1'b0, 32'h0);
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

`ifdef BUS_ARB_TIMEOUT_EN
        // Timeout: master 1 requests, slave never acks
        set_m(1, 1'b1, 1'b0, 32'hE0, 32'h0, 4'hF);
        bif.i_rd_data = 32'h1234;
        tick();
        chk("to_bus_en", bif.o_bus_en, 1'b1);
        for (int c = 1; c < TO; c++) begin
            tick();
            chk($sformatf("to_quiet_%0d", c), bif.o_timeout, 1'b0);
        end
        tick();
        chk("to_pulse", bif.o_timeout, 1'b1);
        chk("to_m_ack", bif.o_m_ack, 2'b10);
        chk("to_rd_data", bif.o_m_rd_data, 32'hFFFF_FFFF);
        tick();
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("to_bus_en_clr", bif.o_bus_en, 1'b0);
        chk("to_timeout_clr", bif.o_timeout, 1'b0);
        slave(1'b1, 32'h0);
        chk("to_late_ack", bif.o_m_ack, 2'b00);
        tick();
        slave(1'b0, 32'h0);
`else
        // Without the timeout feature BUSY waits indefinitely
        set_m(1, 1'b1, 1'b0, 32'hE0, 32'h0, 4'hF);
        tick();
        for (int c = 0; c < 10; c++) begin
            tick();
        end
        chk("noto_still_busy", bif.o_bus_en, 1'b1);
        chk("noto_timeout", bif.o_timeout, 1'b0);
        chk("noto_m_ack", bif.o_m_ack, 2'b00);
        slave(1'b1, 32'h5A5A_5A5A);
        chk("noto_late_m_ack", bif.o_m_ack, 2'b10);
        chk("noto_rd_data", bif.o_m_rd_data, 32'h5A5A_5A5A);
        tick();
        slave(1'b0, 32'h0);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("noto_bus_en_clr", bif.o_bus_en, 1'b0);
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Round-robin arbiter sitting directly downstream of N single-core bus masters (each core's bus-interface BUS master port).
- Grants one master at a time onto a single shared slave bus (memory/interconnect).
- Latches the granted request into registered slave-side outputs.
- Routes the slave acknowledge back to the granted master only, then advances priority.

Parameters:
- N_MASTERS, 2, number of bus masters (≥2).
- XLEN, 32, address/data width.
- TIMEOUT_CYCLES, 256, slave-wait limit; used only with BUS_ARB_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_m_bus_en  in  N_MASTERS  per-master request; held until that master's ack.
- i_m_wr_en  in  N_MASTERS  per-master write flag.
- i_m_addr  in  N_MASTERS*XLEN  flattened addresses; master k at bits [k*XLEN +: XLEN].
- i_m_wr_data  in  N_MASTERS*XLEN  flattened write data.
- i_m_byte_en  in  N_MASTERS*4  flattened byte enables.
- o_m_ack  out  N_MASTERS  one-hot ack pulse to the granted master.
- o_m_rd_data  out  XLEN  read data broadcast to all masters; valid with ack.
- o_bus_en  out  1  slave request.
- o_wr_en  out  1  slave write flag.
- o_addr  out  XLEN  slave address.
- o_wr_data  out  XLEN  slave write data.
- o_byte_en  out  4  slave byte enables.
- i_ack  in  1  slave acknowledge, 1-cycle pulse.
- i_rd_data  in  XLEN  slave read data, valid with i_ack.
- o_timeout  out  1  timeout pulse; tied 0 without the macro.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr 0; grant index 0; timeout counter 0.
- A reset in any cycle, including mid-transaction, returns to IDLE. A pending slave ack is discarded and no master ack is issued.
- States: IDLE, BUSY.
- IDLE:
  - If any i_m_bus_en is set, select the first requesting index scanning rr_ptr, rr_ptr+1, … mod N_MASTERS.
  - Latch the selected index into gnt.
  - Register that master's wr_en, addr, wr_data and byte_en onto the slave outputs.
  - Set o_bus_en=1 and go to BUSY.
  - Latency: request at cycle t → o_bus_en high at t+1.
- BUSY:
  - Slave outputs are held stable from the registered copy and do not track master inputs.
  - On i_ack:
    - o_m_ack[gnt] pulses for exactly that same cycle (combinational from i_ack).
    - o_m_rd_data = i_rd_data (combinational passthrough, always driven).
    - o_bus_en clears at the next edge.
    - rr_ptr ← (gnt+1) mod N_MASTERS.
    - Go to IDLE.
- Every transaction passes through IDLE, so there is at least one idle cycle between transactions. An ack coinciding with new requests defers those requests to the IDLE cycle.
- i_ack in IDLE (spurious) is ignored: no master ack, no state change.
- Masters must drop i_m_bus_en in the cycle after their ack unless issuing a new request. A master deasserting mid-transaction has no effect; the latched request completes and its ack is still pulsed.
- Index arithmetic wraps mod N_MASTERS; non-power-of-two N_MASTERS is supported.
- o_m_ack is never multi-hot.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - BUSY counts cycles without i_ack.
  - When the count reaches TIMEOUT_CYCLES, that cycle pulses o_m_ack[gnt] and forces o_m_rd_data = {XLEN{1'b1}}.
  - o_timeout pulses for the same cycle; rr_ptr advances; state goes to IDLE.
  - A late i_ack for the abandoned transaction is ignored as spurious.
  - The counter clears on entry to BUSY.
- Undefined: no counter logic; o_timeout is constant 0; BUSY waits indefinitely.

Decomposition:
- Shared include header: state encodings (ARB_IDLE, ARB_BUSY), BYTE_EN_W=4, the timeout fill value, and the index-width function clog2(N_MASTERS).
- One natural sub-module, rr_priority_pick: combinational request vector plus rr_ptr → found flag and selected index.
- State, latching and ack routing stay in bus_rr_arbiter.

Test Plan:
- Single request: master 1 requests a read of 0x0000_1000 at cycle 0 → o_bus_en=1, o_addr=0x1000 at cycle 1. Slave acks at cycle 3 with 0xCAFEF00D → o_m_ack=2'b10 and o_m_rd_data=0xCAFEF00D at cycle 3; o_bus_en=0 at cycle 4.
- Contention fairness: N=2, both request continuously from reset, slave acks 1 cycle after o_bus_en → grant order 0,1,0,1. No master receives two consecutive grants while the other is waiting.
- Write latching: master 0 writes 0x12345678 to 0x2000 with byte_en 4'b0011, then changes its inputs while in BUSY → slave outputs stay 0x2000 / 0x12345678 / 4'b0011 until ack.
- Reset mid-operation: i_rst in BUSY coinciding with i_ack → next cycle all outputs 0, o_m_ack 0, rr_ptr 0, IDLE.
- Spurious ack: i_ack=1 with no grant → o_m_ack stays 0, state stays IDLE.
- Timeout (BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): slave never acks → o_timeout and o_m_ack[gnt] pulse 4 cycles after o_bus_en rises, with o_m_rd_data=0xFFFFFFFF. A subsequent i_ack is ignored.
